// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: 1-to-4 TDM demux; ports clk, rst, din/din_valid/sof in, dout/dout_valid/slot/frame_err out, err_cnt when TDM_DEMUX_ERRCNT_EN is defined
module tdm_demux_1to4 #(
  parameter int W = 4,
  localparam int OUTW = 4 * W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  input  logic            sof,
  output logic [OUTW-1:0] dout,
  output logic            dout_valid,
  output logic [1:0]      slot,
  output logic            frame_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]   state;
  logic [W-1:0] lane0, lane1, lane2;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      slot       <= 2'd0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (din_valid && sof) begin
        frame_err <= (state == RUN);
        lane0     <= din;
        slot      <= 2'd1;
        state     <= RUN;
      end else if (din_valid && state == RUN) begin
        if (slot == 2'd3) begin
          dout       <= {din, lane2, lane1, lane0};
          dout_valid <= 1'b1;
          slot       <= 2'd0;
          state      <= IDLE;
        end else begin
          if (slot == 2'd1) lane1 <= din;
          if (slot == 2'd2) lane2 <= din;
          slot <= slot + 2'd1;
        end
      end
    end
  end
`ifdef TDM_DEMUX_ERRCNT_EN
  logic err_ev;
  assign err_ev = din_valid && (sof ? state == RUN : state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= 8'd0;
    else if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb_tdm_demux_1to4: directed self-checking bench for tdm_demux_1to4
module tb_tdm_demux_1to4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  slot;
  logic        frame_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  tdm_demux_1to4 #(.W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .slot(slot), .frame_err(frame_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [3:0] d);
    din_valid = v;
    sof = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 4'h7);
    rst = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic dv, input logic [1:0] sl, input logic fe);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".dv"}, 32'(dout_valid), 32'(dv));
    chk({tag, ".slot"}, 32'(slot), 32'(sl));
    chk({tag, ".ferr"}, 32'(frame_err), 32'(fe));
  endtask

  initial begin
    do_reset();
    do_reset();
    expect_out("reset", 16'h0, 1'b0, 2'd0, 1'b0);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("reset.errcnt", 32'(err_cnt), 32'd0);
`endif
    // full-rate frame
    step(1, 1, 4'hA); expect_out("f1.a", 16'h0, 0, 2'd1, 0);
    step(1, 0, 4'hB); expect_out("f1.b", 16'h0, 0, 2'd2, 0);
    step(1, 0, 4'hC); expect_out("f1.c", 16'h0, 0, 2'd3, 0);
    step(1, 0, 4'hD); expect_out("f1.d", 16'hDCBA, 1, 2'd0, 0);
    step(0, 0, 4'h0); expect_out("f1.after", 16'hDCBA, 0, 2'd0, 0);
    // gapped frame
    step(1, 1, 4'hA);
    for (int i = 0; i < 3; i++) begin step(0, 1, 4'hF); expect_out("gap.a", 16'hDCBA, 0, 2'd1, 0); end
    step(1, 0, 4'hB);
    for (int i = 0; i < 3; i++) begin step(0, 0, 4'hF); expect_out("gap.b", 16'hDCBA, 0, 2'd2, 0); end
    step(1, 0, 4'hC);
    for (int i = 0; i < 3; i++) begin step(0, 0, 4'hF); expect_out("gap.c", 16'hDCBA, 0, 2'd3, 0); end
    step(1, 0, 4'hD); expect_out("gap.d", 16'hDCBA, 1, 2'd0, 0);
    step(0, 0, 4'h0); expect_out("gap.after", 16'hDCBA, 0, 2'd0, 0);
    // back-to-back frames
    step(1, 1, 4'h1); step(1, 0, 4'h2); step(1, 0, 4'h3);
    step(1, 0, 4'h4); expect_out("b2b.1", 16'h4321, 1, 2'd0, 0);
    step(1, 1, 4'h5); expect_out("b2b.5", 16'h4321, 0, 2'd1, 0);
    step(1, 0, 4'h6); expect_out("b2b.6", 16'h4321, 0, 2'd2, 0);
    step(1, 0, 4'h7); expect_out("b2b.7", 16'h4321, 0, 2'd3, 0);
    step(1, 0, 4'h8); expect_out("b2b.8", 16'h8765, 1, 2'd0, 0);
    step(0, 0, 4'h0); expect_out("b2b.after", 16'h8765, 0, 2'd0, 0);
    // premature sof
    do_reset();
    expect_out("pre.rst", 16'h0, 0, 2'd0, 0);
    step(1, 1, 4'h1); step(1, 0, 4'h2); expect_out("pre.2", 16'h0, 0, 2'd2, 0);
    step(1, 1, 4'h9); expect_out("pre.9", 16'h0, 0, 2'd1, 1);
    step(1, 0, 4'hA); expect_out("pre.a", 16'h0, 0, 2'd2, 0);
    step(1, 0, 4'hB); expect_out("pre.b", 16'h0, 0, 2'd3, 0);
    step(1, 0, 4'hC); expect_out("pre.c", 16'hCBA9, 1, 2'd0, 0);
    step(0, 0, 4'h0); expect_out("pre.after", 16'hCBA9, 0, 2'd0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("pre.errcnt", 32'(err_cnt), 32'd1);
`endif
    // idle garbage
    for (int i = 0; i < 3; i++) begin step(1, 0, 4'hF); expect_out("idle", 16'hCBA9, 0, 2'd0, 0); end
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("idle.errcnt", 32'(err_cnt), 32'd4);
`endif
    // mid-frame reset
    step(1, 1, 4'h1); step(1, 0, 4'h2); expect_out("mid.2", 16'hCBA9, 0, 2'd2, 0);
    do_reset();
    expect_out("mid.rst", 16'h0, 0, 2'd0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("mid.errcnt", 32'(err_cnt), 32'd0);
`endif
    step(1, 0, 4'h3); expect_out("mid.drop", 16'h0, 0, 2'd0, 0);
    step(1, 1, 4'h5); step(1, 0, 4'h6); step(1, 0, 4'h7);
    step(1, 0, 4'h8); expect_out("mid.clean", 16'h8765, 1, 2'd0, 0);
    step(0, 0, 4'h0); expect_out("mid.after", 16'h8765, 0, 2'd0, 0);
`ifdef TDM_DEMUX_ERRCNT_EN
    for (int i = 0; i < 300; i++) step(1, 0, 4'h1);
    chk("sat.300", 32'(err_cnt), 32'hFF);
    step(1, 0, 4'h1);
    chk("sat.hold", 32'(err_cnt), 32'hFF);
    do_reset();
    chk("sat.rst", 32'(err_cnt), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
Time-division 1-to-4 demultiplexer, the receive-side counterpart of the 4:1 mux datapath. It accepts a serial stream of W-bit beats with a start-of-frame marker. Each 4-beat frame is steered into lanes 0..3 by an internal slot counter. The assembled 4-lane word is presented with a one-cycle valid pulse, for downstream blocks that need the de-serialised channels in parallel.

Parameters:
W, 4, width of one lane / one input beat
OUTW, 4*W, width of packed output word (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
din  input  W  serial input beat
din_valid  input  1  beat qualifier; din and sof sampled only when high
sof  input  1  start of frame; marks the beat as lane 0
dout  output  OUTW  packed lanes: lane0=dout[W-1:0], lane3=dout[4W-1:3W]
dout_valid  output  1  one-cycle pulse when dout updates with a complete frame
slot  output  2  lane index the next accepted beat will fill (0 when IDLE)
frame_err  output  1  one-cycle pulse on premature sof (partial frame dropped)

Behaviour:
- Reset is synchronous, active-high, and applies on the clk edge where rst=1. It overrides all inputs that cycle. Reset values: state=IDLE, slot=0, dout=0, dout_valid=0, frame_err=0, lane shadow regs=0.
- Reset asserted mid-frame discards the partial frame. No dout_valid and no frame_err are raised for it.
- States: IDLE (waiting for sof), RUN (frame in progress).
- IDLE:
  - din_valid=1, sof=1: capture din into lane0 shadow, slot<=1, go to RUN.
  - din_valid=1, sof=0: beat dropped silently; stay in IDLE.
  - din_valid=0: hold.
- RUN, din_valid=0: hold all state. Gaps of any length are allowed inside a frame.
- RUN, din_valid=1, sof=0, slot in 1..2: capture din into lane[slot] shadow, slot<=slot+1.
- RUN, din_valid=1, sof=0, slot=3 (frame completion):
  - dout <= {din, lane2, lane1, lane0}.
  - dout_valid<=1 on the next cycle.
  - slot<=0, go to IDLE.
- RUN, din_valid=1, sof=1 (premature sof, any slot):
  - frame_err<=1 for one cycle; partial frame discarded; dout unchanged.
  - This beat becomes lane0 of a new frame: slot<=1, stay in RUN.
- Latency: dout/dout_valid update on the clock edge that accepts the lane-3 beat, so they are visible in the cycle after that beat.
- Back-to-back frames at full rate are supported. The sof beat immediately following the lane-3 beat is accepted from IDLE with no bubble, giving one dout_valid every 4 cycles.
- dout holds its last complete frame until the next completion. dout_valid and frame_err are never high for more than one consecutive cycle per event.
- slot wraps 3->0 only on frame completion. It never wraps via increment.

Optional Feature:
Macro TDM_DEMUX_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - Increments on every frame_err pulse and also on every beat dropped in IDLE (din_valid=1, sof=0).
  - Saturates at 8'hFF; reset to 0 by rst.
  - If both events occur in the same cycle, it increments once. They are mutually exclusive by state.
- Not defined: port absent; counter logic absent; all other behaviour identical.

Test Plan:
- Reset then a frame at W=4: beats sof=1 din=4'hA, then 4'hB, 4'hC, 4'hD, all on consecutive cycles with din_valid=1 -> one cycle after the 4'hD beat, dout=16'hDCBA and dout_valid=1 for exactly one cycle; slot sequence 0,1,2,3,0.
- Gapped frame: same beats with din_valid=0 for 3 cycles between each -> same dout=16'hDCBA, single dout_valid pulse, slot holds during gaps.
- Two back-to-back frames 1,2,3,4 then 5,6,7,8 with no idle cycles -> dout=16'h4321 then 16'h8765, dout_valid pulses exactly 4 cycles apart.
- Premature sof: sof beat 4'h1, beat 4'h2, then sof beat 4'h9, beats 4'hA, 4'hB, 4'hC -> frame_err pulses once at the 4'h9 beat; only one dout_valid, with dout=16'hCBA9; dout=0 before it.
- IDLE garbage plus mid-frame reset: din_valid=1 sof=0 beats in IDLE -> no state change. Then start a frame, assert rst after 2 beats -> slot=0, no dout_valid, dout=0. A following clean frame completes normally. With TDM_DEMUX_ERRCNT_EN, err_cnt counts the IDLE drops and clears on rst.
- Saturation (TDM_DEMUX_ERRCNT_EN only): 300 IDLE-dropped beats -> err_cnt=8'hFF and stays there.
